// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, types and address helpers for the FFT address generator
package fft_pkg;
  localparam int N_LOG2    = 8;
  localparam int N         = 1 << N_LOG2;
  localparam int RD_LAT    = 1;
  localparam int BF_LAT    = 3;
  localparam int DRAIN_CYC = RD_LAT + BF_LAT;
  localparam int STAGE_W   = $clog2(N_LOG2);
  localparam int K_W       = N_LOG2 - 1;
  localparam int DCNT_W    = $clog2(DRAIN_CYC + 1);

  typedef logic [N_LOG2-1:0]  addr_t;
  typedef logic [N_LOG2-2:0]  tw_t;
  typedef logic [STAGE_W-1:0] stage_t;
  typedef logic [K_W-1:0]     kcnt_t;
  typedef logic [DCNT_W-1:0]  dcnt_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // p = grp*2^(s+1) + pos, with pos = k mod 2^s and grp = k >> s
  function automatic addr_t bf_addr_p(input stage_t s, input kcnt_t k);
    addr_t kk, span, pos, grp;
    kk   = addr_t'(k);
    span = addr_t'(1) << s;
    pos  = kk & (span - addr_t'(1));
    grp  = kk >> s;
    return ((grp << s) << 1) | pos;
  endfunction

  function automatic addr_t bf_addr_q(input stage_t s, input kcnt_t k);
    return bf_addr_p(s, k) + (addr_t'(1) << s);
  endfunction

  function automatic tw_t bf_tw(input stage_t s, input kcnt_t k);
    addr_t pos;
    pos = addr_t'(k) & ((addr_t'(1) << s) - addr_t'(1));
    return tw_t'(pos << (stage_t'(N_LOG2 - 1) - s));
  endfunction
endpackage

// File: rtl/fft_delay_line.sv
// rtl/fft_delay_line.sv - WIDTH x DEPTH shift register with asynchronous active-low clear
module fft_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[DEPTH-1];
endmodule

// File: rtl/fft_addr_gen.sv
// rtl/fft_addr_gen.sv - in-place radix-2 DIT FFT stage/butterfly address sequencer
module fft_addr_gen
  import fft_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [STAGE_W-1:0] stage,
  output logic               rd_en,
  output logic [N_LOG2-1:0]  rd_addr_p,
  output logic [N_LOG2-1:0]  rd_addr_q,
  output logic [N_LOG2-2:0]  tw_addr,
  output logic               bf_en,
  output logic               wr_en,
  output logic [N_LOG2-1:0]  wr_addr_p,
  output logic [N_LOG2-1:0]  wr_addr_q
);
  localparam kcnt_t  K_LAST = '1;
  localparam stage_t S_LAST = stage_t'(N_LOG2 - 1);
  localparam dcnt_t  D_LAST = dcnt_t'(DRAIN_CYC - 1);
  localparam int     WB_W   = 1 + 2 * N_LOG2;

  state_t state, state_nxt;
  stage_t s, s_nxt;
  kcnt_t  k, k_nxt;
  dcnt_t  dcnt, dcnt_nxt;
  logic   issue;
  logic [WB_W-1:0] wb_bus;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      s         <= '0;
      k         <= '0;
      dcnt      <= '0;
      rd_en     <= 1'b0;
      rd_addr_p <= '0;
      rd_addr_q <= '0;
      tw_addr   <= '0;
    end else begin
      state     <= state_nxt;
      s         <= s_nxt;
      k         <= k_nxt;
      dcnt      <= dcnt_nxt;
      // Issue registers load from the next counters so rd_en lands in the cycle after start
      rd_en     <= issue;
      rd_addr_p <= issue ? bf_addr_p(s_nxt, k_nxt) : '0;
      rd_addr_q <= issue ? bf_addr_q(s_nxt, k_nxt) : '0;
      tw_addr   <= issue ? bf_tw(s_nxt, k_nxt) : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    k_nxt     = k;
    dcnt_nxt  = dcnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          s_nxt     = '0;
          k_nxt     = '0;
        end
      end
      RUN: begin
        if (k == K_LAST) begin
          state_nxt = DRAIN;
          dcnt_nxt  = '0;
        end else begin
          k_nxt = k + 1'b1;
        end
      end
      DRAIN: begin
        // Hold off the next stage until its last write-back has gone out
        if (dcnt == D_LAST) begin
          if (s != S_LAST) begin
            state_nxt = RUN;
            s_nxt     = s + 1'b1;
            k_nxt     = '0;
          end else begin
            state_nxt = DONE;
          end
        end else begin
          dcnt_nxt = dcnt + 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign issue = (state_nxt == RUN);
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign stage = s;

  fft_delay_line #(.WIDTH(1), .DEPTH(RD_LAT)) u_bf_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rd_en),
    .q     (bf_en)
  );

  fft_delay_line #(.WIDTH(WB_W), .DEPTH(RD_LAT + BF_LAT)) u_wb_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({rd_en, rd_addr_p, rd_addr_q}),
    .q     (wb_bus)
  );

  assign {wr_en, wr_addr_p, wr_addr_q} = wb_bus;
endmodule

// File: tb/tb_fft_addr_gen.sv
// tb/tb_fft_addr_gen.sv - directed self-checking bench for fft_addr_gen
module tb_fft_addr_gen;
  logic       clk, rst_n, start;
  logic       busy, done, rd_en, bf_en, wr_en;
  logic [2:0] stage;
  logic [7:0] rd_addr_p, rd_addr_q, wr_addr_p, wr_addr_q;
  logic [6:0] tw_addr;

  int cmp_cnt = 0;
  int err_cnt = 0;

  fft_addr_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .stage     (stage),
    .rd_en     (rd_en),
    .rd_addr_p (rd_addr_p),
    .rd_addr_q (rd_addr_q),
    .tw_addr   (tw_addr),
    .bf_en     (bf_en),
    .wr_en     (wr_en),
    .wr_addr_p (wr_addr_p),
    .wr_addr_q (wr_addr_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference issue schedule: 128 butterflies then 4 drain cycles per stage, 8 stages
  function automatic bit exp_rd(input int c);
    return (c >= 1) && (c <= 1052) && (((c - 1) % 132) < 128);
  endfunction

  function automatic logic [46:0] all_out();
    return {busy, done, stage, rd_en, rd_addr_p, rd_addr_q, tw_addr,
            bf_en, wr_en, wr_addr_p, wr_addr_q};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    cmp_cnt++;
    if (all_out() !== 47'd0) begin
      err_cnt++;
      $display("FAIL reset_state: outputs=%h required 0", all_out());
    end
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      cmp_cnt++;
      if (wr_en !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0) begin
        err_cnt++;
        $display("FAIL idle_after_reset: c=%0d wr_en=%b busy=%b rd_en=%b required 0",
                 c, wr_en, busy, rd_en);
      end
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    cmp_cnt++;
    if (all_out() !== 47'd0) begin
      err_cnt++;
      $display("FAIL async_reset: outputs=%h required 0", all_out());
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_first_issue();
    int n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cmp_cnt++;
    if ({rd_en, busy, bf_en, stage, rd_addr_p, rd_addr_q, tw_addr} !== {1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 8'd1, 7'd0}) begin
      err_cnt++;
      $display("FAIL cycle1: rd_en=%b busy=%b bf_en=%b s=%0d p=%0d q=%0d tw=%0d required 1 1 0 0 0 1 0",
               rd_en, busy, bf_en, stage, rd_addr_p, rd_addr_q, tw_addr);
    end
    @(negedge clk);
    cmp_cnt++;
    if ({rd_en, bf_en, rd_addr_p, rd_addr_q, tw_addr} !== {1'b1, 1'b1, 8'd2, 8'd3, 7'd0}) begin
      err_cnt++;
      $display("FAIL cycle2: rd_en=%b bf_en=%b p=%0d q=%0d tw=%0d required 1 1 2 3 0",
               rd_en, bf_en, rd_addr_p, rd_addr_q, tw_addr);
    end
    repeat (2) @(negedge clk);
    cmp_cnt++;
    if (wr_en !== 1'b0) begin
      err_cnt++;
      $display("FAIL cycle4_wr_en: got %b required 0", wr_en);
    end
    @(negedge clk);
    cmp_cnt++;
    if ({wr_en, wr_addr_p, wr_addr_q} !== {1'b1, 8'd0, 8'd1}) begin
      err_cnt++;
      $display("FAIL cycle5_wb: wr_en=%b wr_p=%0d wr_q=%0d required 1 0 1", wr_en, wr_addr_p, wr_addr_q);
    end
    n = 0;
    while (busy === 1'b1 && n < 1200) begin
      @(negedge clk);
      n++;
    end
    cmp_cnt++;
    if (busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL first_issue_timeout: busy=%b required 0", busy);
    end
  endtask

  task automatic test_stage_addressing();
    int n;
    start = 1'b1;
    for (int c = 1; c <= 930; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 134) begin
        cmp_cnt++;
        if ({rd_en, stage, rd_addr_p, rd_addr_q, tw_addr} !== {1'b1, 3'd1, 8'd1, 8'd3, 7'd64}) begin
          err_cnt++;
          $display("FAIL stage1_k1: rd_en=%b s=%0d p=%0d q=%0d tw=%0d required 1 1 1 3 64",
                   rd_en, stage, rd_addr_p, rd_addr_q, tw_addr);
        end
      end
      if (c == 930) begin
        cmp_cnt++;
        if ({rd_en, stage, rd_addr_p, rd_addr_q, tw_addr} !== {1'b1, 3'd7, 8'd5, 8'd133, 7'd5}) begin
          err_cnt++;
          $display("FAIL stage7_k5: rd_en=%b s=%0d p=%0d q=%0d tw=%0d required 1 7 5 133 5",
                   rd_en, stage, rd_addr_p, rd_addr_q, tw_addr);
        end
      end
    end
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    cmp_cnt++;
    if (busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL stage_addr_timeout: busy=%b required 0", busy);
    end
  endtask

  task automatic test_full_run();
    int pend [256];
    int qp [$];
    int qq [$];
    int rd_cnt, wr_cnt, done_cnt;
    int s, k, span, ep, eq, etw, xp, xq;
    for (int i = 0; i < 256; i++) pend[i] = 0;
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
    start = 1'b1;
    for (int c = 1; c <= 1062; c++) begin
      @(negedge clk);
      start = 1'b0;
      cmp_cnt++;
      if (rd_en !== exp_rd(c) || bf_en !== exp_rd(c - 1) || wr_en !== exp_rd(c - 4) ||
          busy !== (c <= 1057) || done !== (c == 1057)) begin
        err_cnt++;
        $display("FAIL run_ctrl c=%0d: rd=%b bf=%b wr=%b busy=%b done=%b required %b %b %b %b %b",
                 c, rd_en, bf_en, wr_en, busy, done, exp_rd(c), exp_rd(c - 1), exp_rd(c - 4),
                 c <= 1057, c == 1057);
      end
      if (done === 1'b1) done_cnt++;
      if (rd_en === 1'b1) begin
        rd_cnt++;
        s = (c - 1) / 132;
        k = (c - 1) % 132;
        span = 1 << s;
        ep = (k / span) * 2 * span + (k % span);
        eq = ep + span;
        etw = (k % span) * (128 / span);
        cmp_cnt++;
        if (int'(stage) != s || int'(rd_addr_p) != ep || int'(rd_addr_q) != eq || int'(tw_addr) != etw) begin
          err_cnt++;
          $display("FAIL run_addr c=%0d: s=%0d p=%0d q=%0d tw=%0d required %0d %0d %0d %0d",
                   c, stage, rd_addr_p, rd_addr_q, tw_addr, s, ep, eq, etw);
        end
        cmp_cnt++;
        if (pend[rd_addr_p] != 0 || pend[rd_addr_q] != 0) begin
          err_cnt++;
          $display("FAIL raw_hazard c=%0d: pending p=%0d q=%0d required 0 0",
                   c, pend[rd_addr_p], pend[rd_addr_q]);
        end
      end
      if (wr_en === 1'b1) begin
        wr_cnt++;
        cmp_cnt++;
        if (qp.size() == 0) begin
          err_cnt++;
          $display("FAIL wb_order c=%0d: write with no outstanding read, required none", c);
        end else begin
          xp = qp.pop_front();
          xq = qq.pop_front();
          if (int'(wr_addr_p) != xp || int'(wr_addr_q) != xq) begin
            err_cnt++;
            $display("FAIL wb_addr c=%0d: wr_p=%0d wr_q=%0d required %0d %0d", c, wr_addr_p, wr_addr_q, xp, xq);
          end
          pend[xp]--;
          pend[xq]--;
        end
      end
      if (rd_en === 1'b1) begin
        pend[rd_addr_p]++;
        pend[rd_addr_q]++;
        qp.push_back(int'(rd_addr_p));
        qq.push_back(int'(rd_addr_q));
      end
    end
    cmp_cnt++;
    if (rd_cnt != 1024 || wr_cnt != 1024 || done_cnt != 1) begin
      err_cnt++;
      $display("FAIL run_totals: rd=%0d wr=%0d done=%0d required 1024 1024 1", rd_cnt, wr_cnt, done_cnt);
    end
  endtask

  task automatic test_start_held();
    int rd_cnt;
    rd_cnt = 0;
    start = 1'b1;
    for (int c = 1; c <= 1059; c++) begin
      @(negedge clk);
      if (c <= 1058 && rd_en === 1'b1) rd_cnt++;
      if (c == 301) begin
        cmp_cnt++;
        if ({busy, stage} !== {1'b1, 3'd2}) begin
          err_cnt++;
          $display("FAIL busy_start_ignored: busy=%b s=%0d required 1 2", busy, stage);
        end
      end
      if (c == 1058) begin
        cmp_cnt++;
        if ({busy, rd_en} !== 2'b00) begin
          err_cnt++;
          $display("FAIL held_gap_1058: busy=%b rd_en=%b required 0 0", busy, rd_en);
        end
      end
    end
    cmp_cnt++;
    if ({rd_en, stage, rd_addr_p, rd_addr_q} !== {1'b1, 3'd0, 8'd0, 8'd1}) begin
      err_cnt++;
      $display("FAIL held_restart_1059: rd_en=%b s=%0d p=%0d q=%0d required 1 0 0 1",
               rd_en, stage, rd_addr_p, rd_addr_q);
    end
    cmp_cnt++;
    if (rd_cnt != 1024) begin
      err_cnt++;
      $display("FAIL held_single_run: rd_en count=%0d required 1024", rd_cnt);
    end
    start = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1;
    for (int c = 1; c <= 450; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    cmp_cnt++;
    if ({busy, rd_en, stage} !== {1'b1, 1'b1, 3'd3}) begin
      err_cnt++;
      $display("FAIL pre_reset_stage3: busy=%b rd_en=%b s=%0d required 1 1 3", busy, rd_en, stage);
    end
    rst_n = 1'b0;
    #1;
    cmp_cnt++;
    if (all_out() !== 47'd0) begin
      err_cnt++;
      $display("FAIL mid_run_reset: outputs=%h required 0", all_out());
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      cmp_cnt++;
      if ({wr_en, bf_en, rd_en, busy} !== 4'b0000) begin
        err_cnt++;
        $display("FAIL post_reset_quiet c=%0d: wr=%b bf=%b rd=%b busy=%b required 0 0 0 0",
                 c, wr_en, bf_en, rd_en, busy);
      end
    end
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 1) begin
        cmp_cnt++;
        if ({rd_en, stage, rd_addr_p, rd_addr_q} !== {1'b1, 3'd0, 8'd0, 8'd1}) begin
          err_cnt++;
          $display("FAIL restart_first: rd_en=%b s=%0d p=%0d q=%0d required 1 0 0 1",
                   rd_en, stage, rd_addr_p, rd_addr_q);
        end
      end
      cmp_cnt++;
      if (wr_en !== (c == 5)) begin
        err_cnt++;
        $display("FAIL restart_wr_en c=%0d: got %b required %b", c, wr_en, c == 5);
      end
    end
    cmp_cnt++;
    if ({wr_addr_p, wr_addr_q} !== {8'd0, 8'd1}) begin
      err_cnt++;
      $display("FAIL restart_wb_addr: wr_p=%0d wr_q=%0d required 0 1", wr_addr_p, wr_addr_q);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_first_issue();
    test_stage_addressing();
    test_full_run();
    test_start_held();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
